// File: rtl/step_controller.sv
// Board-side step/reset generator for the p18240: synchronises and debounces the
// pushbuttons and run switch, then issues step_en pulses and a clean cpu_reset_L.

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_level,
  output logic o_press,
  output logic o_held
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= RELEASED;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // i_level is the synchronised active-low key: 0 = pressed.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_press     = 1'b0;
    case (r_state)
      RELEASED: begin
        if (!i_level) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (i_level) begin
          w_state_nxt = RELEASED;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = HELD;
          o_press     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      HELD: begin
        if (i_level) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!i_level) begin
          w_state_nxt = HELD;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = RELEASED;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = RELEASED;
    endcase
  end

  assign o_held = (r_state == HELD) || (r_state == RELEASE_WAIT);
endmodule

module step_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RATE_W          = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              key_step_L,
  input  logic              key_reset_L,
  input  logic              run,
  input  logic [RATE_W-1:0] rate,
  output logic              step_en,
  output logic              cpu_reset_L,
  output logic [RATE_W-1:0] step_count,
  output logic              key_held
);
  logic r_step_s1, r_step_s2;
  logic r_rst_s1, r_rst_s2;
  logic r_run_s1, r_run_s2;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_step_s1 <= 1'b1;
      r_step_s2 <= 1'b1;
      r_rst_s1  <= 1'b1;
      r_rst_s2  <= 1'b1;
      r_run_s1  <= 1'b0;
      r_run_s2  <= 1'b0;
    end else begin
      r_step_s1 <= key_step_L;
      r_step_s2 <= r_step_s1;
      r_rst_s1  <= key_reset_L;
      r_rst_s2  <= r_rst_s1;
      r_run_s1  <= run;
      r_run_s2  <= r_run_s1;
    end
  end

  logic w_step_press, w_step_held;
  logic w_rst_press, w_rst_held;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clock   (clock),
    .reset   (reset),
    .i_level (r_step_s2),
    .o_press (w_step_press),
    .o_held  (w_step_held)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_db (
    .clock   (clock),
    .reset   (reset),
    .i_level (r_rst_s2),
    .o_press (w_rst_press),
    .o_held  (w_rst_held)
  );

  logic              r_cpu_reset_L;
  logic              r_step_en;
  logic [RATE_W-1:0] r_div;
  logic [RATE_W-1:0] r_step_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cpu_reset_L <= 1'b0;
      r_step_en     <= 1'b0;
      r_div         <= '0;
      r_step_count  <= '0;
    end else begin
      r_cpu_reset_L <= !w_rst_held;
      if (!r_cpu_reset_L) begin
        r_step_en    <= 1'b0;
        r_div        <= '0;
        r_step_count <= '0;
      end else begin
        if (r_step_en) r_step_count <= r_step_count + 1'b1;
        // >= lets a lowered rate fire immediately instead of wrapping the divider.
        if (r_run_s2) begin
          if (r_div >= rate) begin
            r_step_en <= 1'b1;
            r_div     <= '0;
          end else begin
            r_step_en <= 1'b0;
            r_div     <= r_div + 1'b1;
          end
        end else begin
          r_step_en <= w_step_press;
          r_div     <= '0;
        end
      end
    end
  end

  assign step_en     = r_step_en;
  assign cpu_reset_L = r_cpu_reset_L;
  assign step_count  = r_step_count;
  assign key_held    = w_step_held;

  logic w_unused;
  assign w_unused = w_rst_press;
endmodule
